// File: rtl/plot_capture_fb.sv
// plot_capture_fb: captures pixel plots into a 32x64 colour framebuffer and
// streams the buffer back out in scan order (y fastest) over valid/ready.
// Optional macro PLOT_COLLISION_DETECT_EN adds a sticky collision output.
//
// Ports:
//   clock, reset            - system clock, synchronous active-high reset
//   x, y, colour, plot      - plot bus, one pixel write per cycle while plot
//   dump_start              - request to stream the framebuffer out
//   busy                    - high while clearing or dumping
//   out_x/out_y/out_colour  - presented pixel, qualified by out_valid
//   out_ready               - consumer accept
//   dump_done               - one-cycle pulse after the last pixel is accepted
//   collision               - (macro only) sticky overdraw flag
module plot_capture_fb #(
  parameter int unsigned         X_W       = 5,
  parameter int unsigned         Y_W       = 6,
  parameter int unsigned         COLOUR_W  = 3,
  parameter logic [COLOUR_W-1:0] BG_COLOUR = 3'b001
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [X_W-1:0]      x,
  input  logic [Y_W-1:0]      y,
  input  logic [COLOUR_W-1:0] colour,
  input  logic                plot,
  input  logic                dump_start,
  output logic                busy,
  output logic [X_W-1:0]      out_x,
  output logic [Y_W-1:0]      out_y,
  output logic [COLOUR_W-1:0] out_colour,
  output logic                out_valid,
  input  logic                out_ready,
`ifdef PLOT_COLLISION_DETECT_EN
  output logic                collision,
`endif
  output logic                dump_done
);

  localparam int unsigned A_W   = X_W + Y_W;
  localparam int unsigned DEPTH = 1 << A_W;

  typedef enum logic [1:0] {
    S_CLEAR,
    S_IDLE,
    S_FETCH,
    S_PRESENT
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [A_W-1:0]      cnt;
  logic [COLOUR_W-1:0] mem [DEPTH];

  logic [A_W-1:0]      plot_addr;
  logic                plot_acc;
  logic                cnt_last;
  logic                wr_en;
  logic [A_W-1:0]      wr_addr;
  logic [COLOUR_W-1:0] wr_data;
  logic [COLOUR_W-1:0] fetch_colour;

  assign plot_addr = {x, y};
  assign plot_acc  = plot && (state != S_CLEAR);
  assign cnt_last  = (cnt == '1);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_CLEAR;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_CLEAR:   if (cnt_last) state_nxt = S_IDLE;
      S_IDLE:    if (dump_start) state_nxt = S_FETCH;
      S_FETCH:   state_nxt = S_PRESENT;
      S_PRESENT: if (out_ready) state_nxt = cnt_last ? S_IDLE : S_FETCH;
      default:   state_nxt = S_CLEAR;
    endcase
  end

  // The clear sweep owns the write port; otherwise plots write at {x, y}.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = plot_addr;
    wr_data = colour;
    if (!reset) begin
      if (state == S_CLEAR) begin
        wr_en   = 1'b1;
        wr_addr = cnt;
        wr_data = BG_COLOUR;
      end else if (plot) begin
        wr_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Write-first bypass: a plot hitting the address being fetched wins.
  always_comb begin
    fetch_colour = mem[cnt];
    if (plot_acc && (plot_addr == cnt)) begin
      fetch_colour = colour;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt        <= '0;
      out_valid  <= 1'b0;
      dump_done  <= 1'b0;
      out_x      <= '0;
      out_y      <= '0;
      out_colour <= '0;
    end else begin
      dump_done <= 1'b0;
      unique case (state)
        S_CLEAR: begin
          cnt <= cnt + A_W'(1);
        end
        S_IDLE: begin
          if (dump_start) begin
            cnt <= '0;
          end
        end
        S_FETCH: begin
          out_colour     <= fetch_colour;
          {out_x, out_y} <= cnt;
          out_valid      <= 1'b1;
        end
        S_PRESENT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (cnt_last) begin
              dump_done <= 1'b1;
            end else begin
              cnt <= cnt + A_W'(1);
            end
          end
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

`ifdef PLOT_COLLISION_DETECT_EN
  logic [COLOUR_W-1:0] stored_colour;

  assign stored_colour = mem[plot_addr];

  // A dump request in the same cycle as a colliding plot clears the flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      collision <= 1'b0;
    end else if ((state == S_IDLE) && dump_start) begin
      collision <= 1'b0;
    end else if (plot_acc && (stored_colour != BG_COLOUR) &&
                 (colour != BG_COLOUR) && (colour != stored_colour)) begin
      collision <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_plot_capture_fb.sv
module tb_plot_capture_fb;

  logic       clock;
  logic       reset;
  logic [4:0] x;
  logic [5:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       dump_start;
  logic       busy;
  logic [4:0] out_x;
  logic [5:0] out_y;
  logic [2:0] out_colour;
  logic       out_valid;
  logic       out_ready;
  logic       dump_done;
`ifdef PLOT_COLLISION_DETECT_EN
  logic       collision;
  logic       coll_after_start;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [2:0] pix [2048];
  int         n_acc;
  int         order_err;
  int         stab_err;
  int         done_cnt;

  int         inj_k [2];
  logic [4:0] inj_x [2];
  logic [5:0] inj_y [2];
  logic [2:0] inj_c [2];
  bit         pre_plot;
  logic [4:0] pre_x;
  logic [5:0] pre_y;
  logic [2:0] pre_c;

  plot_capture_fb #(
    .X_W      (5),
    .Y_W      (6),
    .COLOUR_W (3),
    .BG_COLOUR(3'b001)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .x         (x),
    .y         (y),
    .colour    (colour),
    .plot      (plot),
    .dump_start(dump_start),
    .busy      (busy),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_colour(out_colour),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef PLOT_COLLISION_DETECT_EN
    .collision (collision),
`endif
    .dump_done (dump_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int count_colour(input logic [2:0] c);
    int n = 0;
    for (int i = 0; i < 2048; i++) begin
      if (pix[i] === c) n++;
    end
    return n;
  endfunction

  task automatic do_plot(input logic [4:0] px, input logic [5:0] py, input logic [2:0] pc);
    plot   = 1'b1;
    x      = px;
    y      = py;
    colour = pc;
    @(negedge clock);
    plot = 1'b0;
  endtask

  task automatic wait_clear(input string tag);
    for (int i = 0; i < 2048; i++) begin
      if (i == 2047) check({tag, "_busy_hi"}, busy, 1);
      @(negedge clock);
    end
    check({tag, "_busy_lo"}, busy, 0);
  endtask

  // Runs one full dump; rmode 0 = ready always high, 1 = high 1 of 4 cycles.
  task automatic run_dump(input int rmode);
    int         idx;
    int         cyc;
    int         tail;
    bit         arm [2];
    bit         hold;
    logic [4:0] px;
    logic [5:0] py;
    logic [2:0] pc;
    logic [10:0] idx_a;
    idx = 0; cyc = 0; tail = 0; hold = 0;
    arm[0] = 0; arm[1] = 0;
    px = '0; py = '0; pc = '0;
    order_err = 0; stab_err = 0; done_cnt = 0;
    for (int i = 0; i < 2048; i++) pix[i] = '0;
    dump_start = 1'b1;
    if (pre_plot) begin
      plot = 1'b1; x = pre_x; y = pre_y; colour = pre_c;
    end
    @(negedge clock);
    dump_start = 1'b0;
    plot = 1'b0;
`ifdef PLOT_COLLISION_DETECT_EN
    coll_after_start = collision;
`endif
    while (cyc < 20000) begin
      plot = 1'b0;
      for (int j = 0; j < 2; j++) begin
        if (arm[j]) begin
          plot = 1'b1; x = inj_x[j]; y = inj_y[j]; colour = inj_c[j];
          arm[j] = 0;
        end
      end
      if (dump_done) done_cnt++;
      if (tail > 0 || dump_done) tail++;
      if (tail == 2) break;
      if (hold && (!out_valid || out_x != px || out_y != py || out_colour != pc)) stab_err++;
      out_ready = (rmode == 0) ? 1'b1 : ((cyc % 4) == 0);
      hold = out_valid && !out_ready;
      px = out_x; py = out_y; pc = out_colour;
      if (out_valid && out_ready) begin
        if (idx < 2048) begin
          idx_a = idx[10:0];
          pix[idx] = out_colour;
          if ({out_x, out_y} != idx_a) order_err++;
        end
        for (int j = 0; j < 2; j++) begin
          if (inj_k[j] == idx) arm[j] = 1;
        end
        idx++;
      end
      @(negedge clock);
      cyc++;
    end
    out_ready = 1'b0;
    plot = 1'b0;
    n_acc = idx;
    check("dump_timeout", cyc >= 20000, 0);
    inj_k[0] = -1; inj_k[1] = -1;
    pre_plot = 0;
  endtask

  initial begin
    int  found;
    int  done_seen;
    int  valid_seen;

    reset = 1'b1; x = '0; y = '0; colour = '0; plot = 1'b0;
    dump_start = 1'b0; out_ready = 1'b0;
    inj_k[0] = -1; inj_k[1] = -1; pre_plot = 0;
    pre_x = '0; pre_y = '0; pre_c = '0;
    for (int j = 0; j < 2; j++) begin
      inj_x[j] = '0; inj_y[j] = '0; inj_c[j] = '0;
    end

    repeat (3) @(negedge clock);
    check("rst_valid", out_valid, 0);
    check("rst_done", dump_done, 0);
    check("rst_busy", busy, 1);
    check("rst_outxy", {out_x, out_y, out_colour}, 0);
`ifdef PLOT_COLLISION_DETECT_EN
    check("rst_collision", collision, 0);
`endif
    reset = 1'b0;
    wait_clear("clr0");

    // Freshly cleared frame.
    run_dump(0);
    check("d1_count", n_acc, 2048);
    check("d1_order", order_err, 0);
    check("d1_bg", count_colour(3'b001), 2048);
    check("d1_done", done_cnt, 1);
    check("d1_busy", busy, 0);

    // Two plotted pixels, including the final address.
    do_plot(5'd3, 6'd5, 3'b010);
    do_plot(5'd31, 6'd63, 3'b100);
    run_dump(0);
    check("d2_pix197", pix[197], 3'b010);
    check("d2_pix2047", pix[2047], 3'b100);
    check("d2_bg", count_colour(3'b001), 2046);
    check("d2_done", done_cnt, 1);

    // Backpressured dump.
    run_dump(1);
    check("d3_count", n_acc, 2048);
    check("d3_order", order_err, 0);
    check("d3_stable", stab_err, 0);
    check("d3_done", done_cnt, 1);
    check("d3_pix197", pix[197], 3'b010);
    check("d3_pix2047", pix[2047], 3'b100);

    // Writes during a dump: one to the address being fetched, one behind.
    inj_k[0] = 0;   inj_x[0] = 5'd0; inj_y[0] = 6'd0; inj_c[0] = 3'b110;
    inj_k[1] = 196; inj_x[1] = 5'd3; inj_y[1] = 6'd5; inj_c[1] = 3'b111;
    run_dump(0);
    check("d4_pix197_wf", pix[197], 3'b111);
    check("d4_pix0_old", pix[0], 3'b001);
    check("d4_count", n_acc, 2048);
    check("d4_bg", count_colour(3'b001), 2046);

    run_dump(0);
    check("d5_pix0", pix[0], 3'b110);
    check("d5_pix197", pix[197], 3'b111);
    check("d5_pix2047", pix[2047], 3'b100);
    check("d5_bg", count_colour(3'b001), 2045);

    // Reset in the middle of a dump at pixel 1000 (x=15, y=40).
    dump_start = 1'b1;
    @(negedge clock);
    dump_start = 1'b0;
    out_ready = 1'b1;
    found = 0;
    for (int i = 0; i < 5000; i++) begin
      if (out_valid && {out_x, out_y} == 11'd1000) begin
        found = 1;
        break;
      end
      @(negedge clock);
    end
    check("mid_found", found, 1);
    reset = 1'b1;
    out_ready = 1'b0;
    @(negedge clock);
    check("mid_valid", out_valid, 0);
    check("mid_busy", busy, 1);
    check("mid_done", dump_done, 0);
    reset = 1'b0;
    done_seen = 0;
    valid_seen = 0;
    for (int i = 0; i < 2048; i++) begin
      dump_start = (i == 100);
      if (dump_done) done_seen++;
      if (out_valid) valid_seen++;
      if (i == 2047) check("mid_busy_hi", busy, 1);
      @(negedge clock);
    end
    dump_start = 1'b0;
    check("mid_busy_lo", busy, 0);
    check("mid_no_done", done_seen, 0);
    check("mid_no_valid", valid_seen + out_valid, 0);

    // Cleared again; plot and dump_start in the same idle cycle.
    pre_plot = 1; pre_x = 5'd10; pre_y = 6'd20; pre_c = 3'b101;
    run_dump(0);
    check("d6_count", n_acc, 2048);
    check("d6_order", order_err, 0);
    check("d6_pix660", pix[660], 3'b101);
    check("d6_bg", count_colour(3'b001), 2047);
    check("d6_done", done_cnt, 1);

`ifdef PLOT_COLLISION_DETECT_EN
    check("col_init", collision, 0);
    do_plot(5'd4, 6'd4, 3'b010);
    do_plot(5'd4, 6'd4, 3'b010);
    check("col_same", collision, 0);
    do_plot(5'd2, 6'd2, 3'b010);
    check("col_first", collision, 0);
    do_plot(5'd2, 6'd2, 3'b100);
    check("col_set", collision, 1);
    @(negedge clock);
    check("col_sticky", collision, 1);
    run_dump(0);
    check("col_cleared", coll_after_start, 0);
    check("col_after", collision, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
